// File: rtl/uart_record_assembler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_record_assembler_if : UART byte stream in, AXI-S record stream out  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface uart_record_assembler_if #(
  parameter int REC_BYTES = 32
);
  logic [7:0]             s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic [REC_BYTES*8-1:0] m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface
`default_nettype wire

// File: rtl/uart_record_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_record_assembler : packs UART RX bytes into one-beat AXI-S records  |
// | with inter-byte timeout. UART_REC_ASM_STATS_EN adds rec/drop counters.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_record_assembler #(
  parameter int REC_BYTES      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  uart_record_assembler_if.slave axis
`ifdef UART_REC_ASM_STATS_EN
  ,
  output logic [31:0] rec_count,
  output logic [15:0] drop_count
`endif
);

  localparam int W     = REC_BYTES * 8;
  localparam int IDX_W = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(REC_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     rec_q, rec_d;
  logic             vld_q, vld_d;

  logic w_ready;
  logic w_accept;
  logic w_load;
  logic w_timeout;

  always_comb begin
    // Only the final byte of a record can be blocked by a held output.
    w_ready   = (idx_q != IDX_LAST) || !vld_q || axis.m_axis_tready;
    w_accept  = axis.s_axis_tvalid && w_ready;
    w_load    = w_accept && (idx_q == IDX_LAST);
    w_timeout = (TIMEOUT_CYCLES != 0) && (idx_q != '0) && (idle_q == CNT_LIMIT) && !w_accept;

    acc_d = acc_q;
    for (int k = 0; k < REC_BYTES; k++) begin
      if (w_accept && (idx_q == IDX_W'(k))) begin
        acc_d[8*k +: 8] = axis.s_axis_tdata;
      end
    end

    idx_d = idx_q;
    if (w_accept) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else if (w_timeout) begin
      idx_d = '0;
    end

    idle_d = idle_q;
    if (w_accept || (idx_q == '0) || w_timeout) begin
      idle_d = '0;
    end else if ((TIMEOUT_CYCLES != 0) && w_ready && !axis.s_axis_tvalid) begin
      idle_d = idle_q + 1'b1;
    end

    rec_d = rec_q;
    vld_d = vld_q;
    if (w_load) begin
      rec_d = acc_d;
      vld_d = 1'b1;
    end else if (vld_q && axis.m_axis_tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      idle_q <= '0;
      acc_q  <= '0;
      rec_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      idle_q <= idle_d;
      acc_q  <= acc_d;
      rec_q  <= rec_d;
      vld_q  <= vld_d;
    end
  end

  assign axis.s_axis_tready = w_ready;
  assign axis.m_axis_tdata  = rec_q;
  assign axis.m_axis_tvalid = vld_q;
  assign axis.m_axis_tlast  = vld_q;

`ifdef UART_REC_ASM_STATS_EN
  logic [31:0] rec_count_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (w_load) begin
        rec_count_q <= rec_count_q + 32'd1;
      end
      if (w_timeout && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  assign rec_count  = rec_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_record_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_record_assembler : directed stimulus, queue-based record checks  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_record_assembler;

  localparam int REC_BYTES = 32;
  localparam int TMO       = 100;
  localparam int W         = REC_BYTES * 8;

  localparam logic [W-1:0] REC_SEQ = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [W-1:0] REC_MKT = 256'h00000000_0000003f_80000042_c8000001_00000000_0000002a_11223344_55667788;
  localparam logic [W-1:0] REC_40  = 256'h5f5e5d5c_5b5a5958_57565554_53525150_4f4e4d4c_4b4a4948_47464544_43424140;
  localparam logic [W-1:0] REC_60  = 256'h7f7e7d7c_7b7a7978_77767574_73727170_6f6e6d6c_6b6a6968_67666564_63626160;
  localparam logic [W-1:0] REC_A0  = 256'hbfbebdbc_bbbab9b8_b7b6b5b4_b3b2b1b0_afaeadac_abaaa9a8_a7a6a5a4_a3a2a1a0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_record_assembler_if #(.REC_BYTES(REC_BYTES)) axis ();

`ifdef UART_REC_ASM_STATS_EN
  logic [31:0] rec_count;
  logic [15:0] drop_count;
`endif

  uart_record_assembler #(
    .REC_BYTES      (REC_BYTES),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axis       (axis.slave)
`ifdef UART_REC_ASM_STATS_EN
    ,
    .rec_count  (rec_count),
    .drop_count (drop_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  logic [W-1:0] exp_q [$];

  logic [7:0] mkt_bytes [REC_BYTES] = '{
    8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11,
    8'h2a, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h00, 8'h00, 8'hc8, 8'h42, 8'h00, 8'h00, 8'h80,
    8'h3f, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: a beat sampled valid&&ready at the negedge is consumed on the next posedge.
  always @(negedge clk) begin
    if (rst_n && axis.m_axis_tvalid && axis.m_axis_tready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h required no beat", axis.m_axis_tdata);
      end else begin
        check("record_tdata", axis.m_axis_tdata, exp_q.pop_front());
        check("record_tlast", W'(axis.m_axis_tlast), W'(1));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    axis.s_axis_tdata  = b;
    axis.s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = axis.s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    axis.s_axis_tvalid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted in %0d cycles, required acceptance", b, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset_tvalid", W'(axis.m_axis_tvalid), W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    axis.s_axis_tdata  = 8'h00;
    axis.s_axis_tvalid = 1'b0;
    axis.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", W'(axis.m_axis_tvalid), W'(0));
    check("rst_tdata",  axis.m_axis_tdata, '0);
    check("rst_tlast",  W'(axis.m_axis_tlast), W'(0));
    check("rst_s_tready", W'(axis.s_axis_tready), W'(1));
`ifdef UART_REC_ASM_STATS_EN
    check("rst_rec_count",  W'(rec_count), W'(0));
    check("rst_drop_count", W'(drop_count), W'(0));
`endif
    rst_n = 1'b1;
    idle(2);

    // Sequential bytes, with one-cycle latency from last byte to valid
    exp_q.push_back(REC_SEQ);
    for (int i = 0; i < REC_BYTES; i++) begin
      send_byte(8'(i));
      if (i == REC_BYTES - 2) check("tvalid_before_last", W'(axis.m_axis_tvalid), W'(0));
    end
    check("tvalid_latency", W'(axis.m_axis_tvalid), W'(1));
    idle(3);

    // Little-endian market-data record
    exp_q.push_back(REC_MKT);
    for (int i = 0; i < REC_BYTES; i++) send_byte(mkt_bytes[i]);
    idle(3);

    // Backpressure: 63 bytes flow, the 64th stalls until the output drains
    axis.m_axis_tready = 1'b0;
    exp_q.push_back(REC_40);
    exp_q.push_back(REC_60);
    for (int i = 0; i < 2 * REC_BYTES - 1; i++) send_byte(8'(8'h40 + i));
    axis.s_axis_tdata  = 8'h7f;
    axis.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_s_tready", W'(axis.s_axis_tready), W'(0));
      check("stall_tvalid",   W'(axis.m_axis_tvalid), W'(1));
      check("stall_tdata",    axis.m_axis_tdata, REC_40);
    end
    @(posedge clk);
    #1;
    axis.m_axis_tready = 1'b1;
    send_byte(8'h7f);
    idle(3);

    // Timeout discards a 10-byte partial record
    pulse_reset();
    exp_q.push_back(REC_A0);
    for (int i = 0; i < 10; i++) send_byte(8'h55);
    idle(TMO + 1);
    for (int i = 0; i < REC_BYTES; i++) send_byte(8'(8'ha0 + i));
    idle(3);
`ifdef UART_REC_ASM_STATS_EN
    check("tmo_rec_count",  W'(rec_count), W'(1));
    check("tmo_drop_count", W'(drop_count), W'(1));
`endif

    // Byte arriving in the timeout cycle wins and lands in lane 10
    pulse_reset();
    exp_q.push_back(REC_SEQ);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    idle(TMO);
    for (int i = 10; i < REC_BYTES; i++) send_byte(8'(i));
    idle(3);
`ifdef UART_REC_ASM_STATS_EN
    check("edge_rec_count",  W'(rec_count), W'(1));
    check("edge_drop_count", W'(drop_count), W'(0));
`endif

    // Reset mid-record, then a clean record
    for (int i = 0; i < 15; i++) send_byte(8'hee);
    pulse_reset();
    exp_q.push_back(REC_SEQ);
    for (int i = 0; i < REC_BYTES; i++) send_byte(8'(i));
    idle(3);

    // Reset while a record is held at the output
    axis.m_axis_tready = 1'b0;
    for (int i = 0; i < REC_BYTES; i++) send_byte(8'hcc);
    check("held_tvalid", W'(axis.m_axis_tvalid), W'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", W'(axis.m_axis_tvalid), W'(0));
    check("async_rst_tdata",  axis.m_axis_tdata, '0);
    idle(2);
    rst_n = 1'b1;
    axis.m_axis_tready = 1'b1;
    exp_q.push_back(REC_SEQ);
    for (int i = 0; i < REC_BYTES; i++) send_byte(8'(i));
    idle(4);

    check("queue_empty", W'(exp_q.size()), W'(0));
    check("beat_count",  W'(n_beats), W'(8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
